// File: rtl/tdp_wr_pair_loader.sv
// Write stage for the 256x9 true dual-port RAM: fills frames from address 0 upward.
// Define RAM_PAIR_WRITE_EN to merge word pairs onto ports A and B in a single cycle.
module tdp_wr_pair_loader #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              weA,
    output logic [ADDR_W-1:0] addrA,
    output logic [DATA_W-1:0] dinA,
    output logic              weB,
    output logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] dinB,
    output logic              done,
    output logic [ADDR_W-1:0] frame_len
);

`ifdef RAM_PAIR_WRITE_EN
    typedef enum logic [1:0] {StEmpty, StHeld, StDone} stateT;
`else
    typedef enum logic [1:0] {StEmpty, StDone} stateT;
`endif

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] cntQ, cntD;
    logic              runQ;
    logic              weAQ, weAD;
    logic [ADDR_W-1:0] addrAQ, addrAD;
    logic [DATA_W-1:0] dinAQ, dinAD;
    logic [ADDR_W-1:0] frameLenQ, frameLenD;
    logic              accept;
    logic              isFinal;
    logic [ADDR_W-1:0] nextCnt;

`ifdef RAM_PAIR_WRITE_EN
    logic [DATA_W-1:0] holdQ, holdD;
    logic              weBQ, weBD;
    logic [ADDR_W-1:0] addrBQ, addrBD;
    logic [DATA_W-1:0] dinBQ, dinBD;
`endif

    // runQ keeps s_ready low until the first clock after reset release
    assign s_ready   = runQ && (stateQ != StDone);
    assign accept    = s_valid && s_ready;
    assign isFinal   = s_last || (cntQ == ADDR_W'(DEPTH - 1));
    assign nextCnt   = cntQ + ADDR_W'(1);
    assign done      = (stateQ == StDone);
    assign frame_len = frameLenQ;
    assign weA       = weAQ;
    assign addrA     = addrAQ;
    assign dinA      = dinAQ;

`ifdef RAM_PAIR_WRITE_EN
    assign weB   = weBQ;
    assign addrB = addrBQ;
    assign dinB  = dinBQ;
`else
    assign weB   = 1'b0;
    assign addrB = '0;
    assign dinB  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StEmpty;
            cntQ      <= '0;
            runQ      <= 1'b0;
            weAQ      <= 1'b0;
            addrAQ    <= '0;
            dinAQ     <= '0;
            frameLenQ <= '0;
`ifdef RAM_PAIR_WRITE_EN
            holdQ     <= '0;
            weBQ      <= 1'b0;
            addrBQ    <= '0;
            dinBQ     <= '0;
`endif
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            runQ      <= 1'b1;
            weAQ      <= weAD;
            addrAQ    <= addrAD;
            dinAQ     <= dinAD;
            frameLenQ <= frameLenD;
`ifdef RAM_PAIR_WRITE_EN
            holdQ     <= holdD;
            weBQ      <= weBD;
            addrBQ    <= addrBD;
            dinBQ     <= dinBD;
`endif
        end
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        weAD      = 1'b0;
        addrAD    = addrAQ;
        dinAD     = dinAQ;
        frameLenD = frameLenQ;
`ifdef RAM_PAIR_WRITE_EN
        holdD     = holdQ;
        weBD      = 1'b0;
        addrBD    = addrBQ;
        dinBD     = dinBQ;
`endif
        case (stateQ)
            StEmpty: begin
                if (accept) begin
`ifdef RAM_PAIR_WRITE_EN
                    if (!isFinal) begin
                        holdD  = s_data;
                        cntD   = nextCnt;
                        stateD = StHeld;
                    end else begin
                        // lone final word goes out on port A only
                        weAD      = 1'b1;
                        addrAD    = cntQ;
                        dinAD     = s_data;
                        frameLenD = nextCnt;
                        stateD    = StDone;
                    end
`else
                    weAD   = 1'b1;
                    addrAD = cntQ;
                    dinAD  = s_data;
                    cntD   = nextCnt;
                    if (isFinal) begin
                        frameLenD = nextCnt;
                        stateD    = StDone;
                    end
`endif
                end
            end
`ifdef RAM_PAIR_WRITE_EN
            StHeld: begin
                if (accept) begin
                    weAD   = 1'b1;
                    addrAD = cntQ - ADDR_W'(1);
                    dinAD  = holdQ;
                    weBD   = 1'b1;
                    addrBD = cntQ;
                    dinBD  = s_data;
                    if (isFinal) begin
                        frameLenD = nextCnt;
                        stateD    = StDone;
                    end else begin
                        cntD   = nextCnt;
                        stateD = StEmpty;
                    end
                end
            end
`endif
            StDone: begin
                cntD   = '0;
                stateD = StEmpty;
            end
            default: stateD = StEmpty;
        endcase
    end

endmodule
